// File: rtl/bus_fabric_decoder.sv
// CPU-side bus decoder: maps an address field onto one-hot slave selects, registers the
// request toward the slave, stalls the CPU until ready, and ends bad or hung accesses with a bus error.
module bus_fabric_decoder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int NUM_SLAVES = 8,
  parameter int SEL_MSB    = 15,
  parameter int SEL_LSB    = 12,
  parameter int TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = '1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        cs,
  output logic                         slv_read,
  output logic                         slv_write,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_ready,
  input  logic                         err_clr,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;

  logic [SEL_W-1:0]  sel;
  logic              mapped;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              err_load;
  logic [ADDR_W-1:0] err_ld_addr;

  assign sel    = cpu_addr[SEL_MSB:SEL_LSB];
  assign mapped = 32'(sel) < NUM_SLAVES;

  // The registered one-hot select doubles as the latched slave index.
  always_comb begin
    sel_ready = |(cs_q & slv_ready);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cs_q[i]) sel_rdata = slv_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_load    = 1'b0;
    err_ld_addr = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_read || cpu_write) begin
          if (mapped && (cpu_read ^ cpu_write)) begin
            state_d = S_ACCESS;
            cnt_d   = '0;
            cs_d    = NUM_SLAVES'(1) << sel;
            rd_d    = cpu_read;
            wr_d    = cpu_write;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            state_d     = S_DONE;
            err_d       = 1'b1;
            err_load    = 1'b1;
            err_ld_addr = cpu_addr;
            if (cpu_read) rdata_d = ERR_DATA;
          end
        end
      end
      S_ACCESS: begin
        if (sel_ready) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (rd_q) rdata_d = sel_rdata;
          cs_d    = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = S_DONE;
          err_d    = 1'b1;
          err_load = 1'b1;
          if (rd_q) rdata_d = ERR_DATA;
          cs_d     = '0;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new error outranks a simultaneous clear so that error is never lost.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (err_load) begin
      err_cnt_d  = err_clr ? ERR_CNT_W'(1) : ((&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1);
      err_addr_d = err_ld_addr;
    end else if (err_clr) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cs_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_stall = rst ? 1'b0 :
                     (state_q == S_IDLE)   ? (cpu_read | cpu_write) :
                     (state_q == S_ACCESS);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign cs        = cs_q;
  assign slv_read  = rd_q;
  assign slv_write = wr_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;
  assign err_count = err_cnt_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_fabric_decoder.sv
// Directed bench for bus_fabric_decoder: an 8-slave instance driven by a vector table and
// hand sequences, plus a 5-slave instance sharing the inputs for the unmapped-range case.
module tb_bus_fabric_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  cpu_addr, cpu_wdata;
  logic         cpu_read, cpu_write;
  logic [127:0] slv_rdata;
  logic [7:0]   slv_ready;
  logic         err_clr;

  logic [15:0] cpu_rdata, slv_addr, slv_wdata, err_addr;
  logic        cpu_stall, cpu_err, slv_read, slv_write;
  logic [7:0]  cs, err_count;

  logic [15:0] cpu_rdata5, slv_addr5, slv_wdata5, err_addr5;
  logic        cpu_stall5, cpu_err5, slv_read5, slv_write5;
  logic [4:0]  cs5;
  logic [7:0]  err_count5;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_cnt;
  logic [15:0] exp_eaddr;

  always #5 clk = ~clk;

  bus_fabric_decoder #(.NUM_SLAVES(8)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err), .cs(cs), .slv_read(slv_read),
    .slv_write(slv_write), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready), .err_clr(err_clr),
    .err_count(err_count), .err_addr(err_addr));

  bus_fabric_decoder #(.NUM_SLAVES(5)) dut5 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata5),
    .cpu_stall(cpu_stall5), .cpu_err(cpu_err5), .cs(cs5), .slv_read(slv_read5),
    .slv_write(slv_write5), .slv_addr(slv_addr5), .slv_wdata(slv_wdata5),
    .slv_rdata(slv_rdata[79:0]), .slv_ready(slv_ready[4:0]), .err_clr(err_clr),
    .err_count(err_count5), .err_addr(err_addr5));

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    int          rdy_slave;
    int          rdy_delay;   // wait cycles before ready; -1 = never
    logic [7:0]  distract;    // ready lines from other slaves held high throughout
    logic [7:0]  exp_cs;
    int          exp_lat;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  k = 0;
    int  held = 0;
    bit  done = 0;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_read  = v.rd;
    cpu_write = v.wr;
    slv_ready = v.distract;
    @(negedge clk);
    chk({v.name, ".stall0"}, cpu_stall, 1);
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      slv_ready = v.distract |
                  ((v.rdy_delay >= 0 && k == 1 + v.rdy_delay) ? (8'd1 << v.rdy_slave) : 8'd0);
      @(negedge clk);
      if (!cpu_stall) done = 1;
      else if (cs == v.exp_cs && slv_read == v.rd && slv_write == v.wr &&
               slv_addr == v.addr && slv_wdata == v.wdata) held++;
    end
    chk({v.name, ".latency"}, k, v.exp_lat);
    chk({v.name, ".cs_held"}, held, (v.exp_cs != 0) ? v.exp_lat - 1 : 0);
    chk({v.name, ".done_cs_strobes"}, {cs, slv_read, slv_write}, 0);
    chk({v.name, ".cpu_err"}, cpu_err, v.exp_err);
    chk({v.name, ".cpu_rdata"}, cpu_rdata, v.exp_rdata);
    if (v.exp_err) begin
      exp_cnt   = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
      exp_eaddr = v.addr;
    end
    chk({v.name, ".err_count"}, err_count, exp_cnt);
    chk({v.name, ".err_addr"}, err_addr, exp_eaddr);
    @(posedge clk); #1;
    cpu_read  = 0;
    cpu_write = 0;
    slv_ready = 0;
  endtask

  initial begin
    vecs[0] = '{"rd_s0",      16'h0010, 16'h0000, 1, 0, 0, 0,  8'h00, 8'h01, 2,  0, 16'h1234};
    vecs[1] = '{"wr_s3",      16'h3ABC, 16'h55AA, 0, 1, 3, 4,  8'h00, 8'h08, 6,  0, 16'h1234};
    vecs[2] = '{"rd_s2_wait", 16'h2004, 16'h0000, 1, 0, 2, 1,  8'h00, 8'h04, 3,  0, 16'h3456};
    vecs[3] = '{"rd_timeout", 16'h2000, 16'h0000, 1, 0, 2, -1, 8'h20, 8'h04, 17, 1, 16'hFFFF};
    vecs[4] = '{"rd_and_wr",  16'h1000, 16'h0000, 1, 1, 0, -1, 8'h00, 8'h00, 1,  1, 16'hFFFF};
    vecs[5] = '{"rd_unmap",   16'h9000, 16'h0000, 1, 0, 0, -1, 8'h00, 8'h00, 1,  1, 16'hFFFF};
    vecs[6] = '{"wr_s7",      16'h7FFE, 16'hC3C3, 0, 1, 7, 2,  8'h40, 8'h80, 4,  0, 16'hFFFF};
    vecs[7] = '{"rd_s5",      16'h5000, 16'h0000, 1, 0, 5, 0,  8'h00, 8'h20, 2,  0, 16'h6789};
    vecs[8] = '{"wr_unmap",   16'hF000, 16'h1111, 0, 1, 0, -1, 8'h00, 8'h00, 1,  1, 16'h6789};
    vecs[9] = '{"wr_timeout", 16'h1000, 16'h0F0F, 0, 1, 1, -1, 8'h20, 8'h02, 17, 1, 16'h6789};

    for (int i = 0; i < 8; i++) slv_rdata[i*16 +: 16] = 16'h1234 + 16'(i) * 16'h1111;
    rst = 1; cpu_addr = 0; cpu_wdata = 0; cpu_read = 0; cpu_write = 0;
    slv_ready = 0; err_clr = 0;
    exp_cnt = 0; exp_eaddr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.outputs", {cs, slv_read, slv_write, cpu_stall, cpu_err}, 0);
    chk("reset.data", {cpu_rdata, slv_addr, slv_wdata}, 0);
    chk("reset.err_state", {err_count, err_addr}, 0);
    @(posedge clk); #1;
    rst = 0;

    // 0x7000 is slave 7 on the 8-slave decoder but unmapped on the 5-slave one.
    cpu_addr = 16'h7000; cpu_read = 1; slv_ready = 8'h80;
    @(negedge clk);
    chk("n5.stall0", {cpu_stall, cpu_stall5}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    chk("n5.done_stall", cpu_stall5, 0);
    chk("n5.cs", cs5, 0);
    chk("n5.err", cpu_err5, 1);
    chk("n5.rdata", cpu_rdata5, 16'hFFFF);
    chk("n5.err_count", err_count5, 1);
    chk("n5.err_addr", err_addr5, 16'h7000);
    chk("n8.access_cs", {cpu_stall, cs}, {1'b1, 8'h80});
    @(posedge clk); #1;
    @(negedge clk);
    chk("n8.done", {cpu_stall, cpu_err, cpu_rdata}, {1'b0, 1'b0, 16'h89AB});
    @(posedge clk); #1;
    cpu_read = 0; slv_ready = 0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Back-to-back unmapped reads: each access is one IDLE plus one DONE cycle.
    cpu_addr = 16'h9000; cpu_read = 1;
    repeat (600) @(posedge clk);
    #1 cpu_read = 0;
    @(negedge clk);
    chk("sat.err_count", err_count, 8'hFF);
    chk("sat.err_addr", err_addr, 16'h9000);
    @(posedge clk); #1;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(negedge clk);
    chk("clr.err_count", err_count, 0);
    chk("clr.err_addr", err_addr, 0);
    @(posedge clk); #1;
    err_clr = 1; cpu_addr = 16'hB000; cpu_read = 1;
    @(posedge clk); #1;
    err_clr = 0;
    @(negedge clk);
    chk("clr_vs_err.count", err_count, 1);
    chk("clr_vs_err.addr", err_addr, 16'hB000);
    chk("clr_vs_err.cpu_err", {cpu_stall, cpu_err}, 2'b01);
    @(posedge clk); #1;
    cpu_read = 0;

    // Reset arriving in the third ACCESS cycle of a hung read.
    @(posedge clk); #1;
    cpu_addr = 16'h2000; cpu_read = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_mid.pre_cs", cs, 8'h04);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid.cs_strobes", {cs, slv_read, slv_write}, 0);
    chk("rst_mid.stall", cpu_stall, 0);
    chk("rst_mid.err_count", err_count, 0);
    @(posedge clk); #1;
    rst = 0; cpu_read = 0;
    exp_cnt = 0; exp_eaddr = 0;
    vecs[0].exp_rdata = 16'h1234;
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_fabric_decoder.md
Name: bus_fabric_decoder

Overview:
- Parametrised successor to the fixed 4-bit chip-select decoder between the processor and its memory-mapped peripherals (RAM, graphics, audio, PS/2, serial).
- Decodes a configurable address field into NUM_SLAVES one-hot chip selects.
- Registers the request toward the selected slave and waits on a per-slave ready handshake, stalling the CPU until the access completes.
- Terminates unmapped, illegal or hung accesses with a bus error, and keeps error-tracking state.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- NUM_SLAVES, 8, number of slave ports (1..2^(SEL_MSB-SEL_LSB+1)).
- SEL_MSB, 15, MSB of the slave-select field.
- SEL_LSB, 12, LSB of the slave-select field.
- TIMEOUT, 16, maximum ACCESS cycles before error (>=1).
- ERR_DATA, all ones, read data returned on error.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock (CPU clock domain).
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  write data.
- cpu_read  in  1  read request; held until cpu_stall is low.
- cpu_write  in  1  write request; held until cpu_stall is low.
- cpu_rdata  out  DATA_W  read data; valid in DONE.
- cpu_stall  out  1  CPU must hold its request and stall.
- cpu_err  out  1  access ended in error; valid in DONE.
- cs  out  NUM_SLAVES  one-hot chip selects, registered.
- slv_read  out  1  registered read strobe.
- slv_write  out  1  registered write strobe.
- slv_addr  out  ADDR_W  registered address.
- slv_wdata  out  DATA_W  registered write data.
- slv_rdata  in  NUM_SLAVES*DATA_W  flattened slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- slv_ready  in  NUM_SLAVES  per-slave completion.
- err_clr  in  1  clears err_count and err_addr.
- err_count  out  ERR_CNT_W  saturating count of errored accesses.
- err_addr  out  ADDR_W  address of the most recent errored access.

Behaviour:
- Reset values: all outputs 0 except cpu_stall=0; FSM in IDLE; timeout counter 0. Reset mid-access aborts it: the cycle after rst, cs=0 and no slave strobe remains.
- Decode: idx = cpu_addr[SEL_MSB:SEL_LSB]. Mapped iff idx < NUM_SLAVES.
- cpu_stall is combinational: 1 in IDLE while (cpu_read|cpu_write); 1 in ACCESS; 0 in DONE; 0 during rst.
- IDLE:
  - Mapped request with exactly one of read/write: latch idx; register cs[idx]=1, the matching strobe, slv_addr and slv_wdata; go to ACCESS; timeout counter=0.
  - Unmapped request, or read and write both high: no cs; go to DONE with error.
- ACCESS:
  - cs and strobe held stable.
  - slv_ready[idx]=1: capture slv_rdata slice idx into cpu_rdata (reads only; writes leave cpu_rdata unchanged); cpu_err=0; go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ready: go to DONE with error.
  - slv_ready from non-selected slaves is ignored.
- DONE (exactly 1 cycle):
  - cs=0, strobes=0; cpu_rdata and cpu_err valid.
  - Next state is IDLE. A request still high in the following IDLE cycle is a new access.
- Error termination:
  - cpu_err=1; cpu_rdata=ERR_DATA for reads.
  - err_addr is loaded with the access address.
  - err_count increments, saturating at all ones.
  - If err_clr and an error load coincide, the error wins: count becomes 1 and err_addr is loaded.
- Latency:
  - Ready in the first ACCESS cycle: the request is seen at cycle 0 and DONE occurs at cycle 2.
  - Each wait cycle adds 1.
  - Error in IDLE: DONE at cycle 1.
- cpu_err and cpu_rdata hold their values after DONE until the next DONE.

Test Plan:
- NUM_SLAVES=8, read 0x0010, slv_ready[0]=1 immediately, slave-0 data 0x1234 -> cs=8'h01 at cycle 1; DONE at cycle 2 with cpu_rdata=0x1234, cpu_err=0; cpu_stall high for cycles 0-1 only.
- Write 0x3ABC, data 0x55AA; slave 3 asserts ready after 4 wait cycles -> cs=8'h08 and slv_write held for 5 cycles; slv_addr=0x3ABC, slv_wdata=0x55AA; DONE at cycle 6.
- NUM_SLAVES=5, read 0x7000 -> no cs; DONE at cycle 1; cpu_err=1, cpu_rdata=0xFFFF, err_count=1, err_addr=0x7000.
- TIMEOUT=16, read slave 2, ready never asserted -> exactly 16 ACCESS cycles, then DONE with cpu_err=1; ready on slave 5 during the access is ignored.
- cpu_read and cpu_write both high on 0x1000 -> error in DONE at cycle 1. Then 300 unmapped accesses -> err_count saturates at 255. err_clr -> 0. err_clr coincident with a new error -> 1.
- rst asserted in the 3rd ACCESS cycle -> next cycle cs=0, strobes=0, cpu_stall=0, err_count=0. A new read after reset completes normally.
